// File: rtl/alu_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_operand_stage                                            |
// | Description : Two-entry (main + skid) operand staging buffer between the   |
// |               decoder and the ALU. Selects ALU operands from the main      |
// |               entry. dec_ready comes straight from a flop, so there is no  |
// |               combinational path from ex_ready to dec_ready.               |
// | Options     : `define ALU_OPERAND_FWD_EN to enable write-back forwarding   |
// |               on capture and into held entries.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_operand_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic [XLEN-1:0] dec_rs1_data,
   input  logic [XLEN-1:0] dec_rs2_data,
   input  logic [XLEN-1:0] dec_pc,
   input  logic [XLEN-1:0] dec_imm,
   input  logic [4:0]      dec_rs1_addr,
   input  logic [4:0]      dec_rs2_addr,
   input  logic [4:0]      dec_rd,
   input  logic            dec_sel_a,
   input  logic            dec_sel_b,
   input  logic [3:0]      dec_alu_op,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] alu_in_0,
   output logic [XLEN-1:0] alu_in_1,
   output logic [3:0]      alu_operation,
   output logic [4:0]      ex_rd
);

   // One buffered instruction; the valid bits live in the state encoding.
   typedef struct packed {
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic            sel_a;
      logic            sel_b;
      logic [3:0]      op;
      logic [4:0]      rd;
   } entry_t;

   // EMPTY: nothing held; BUSY: main valid; FULL: main and skid valid.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t r_state;
   entry_t r_main;
   entry_t r_skid;
   logic   r_dec_ready;
   logic   r_ex_valid;

   entry_t w_new;
   entry_t w_main_upd;
   entry_t w_skid_upd;
   logic   w_accept;
   logic   w_consume;

   assign w_accept  = dec_valid & r_dec_ready;
   assign w_consume = r_ex_valid & ex_ready;

`ifdef ALU_OPERAND_FWD_EN
   // A write-back only qualifies when it targets a real register (x0 never forwards).
   logic w_wb_hit;
   assign w_wb_hit = wb_valid & (wb_rd != 5'd0);
`else
   // Write-back port is kept for a uniform interface but has no effect here.
   logic w_unused_wb;
   assign w_unused_wb = ^{wb_valid, wb_rd, wb_data};
`endif

   // Build the incoming entry, substituting the in-flight write-back value if enabled.
   always_comb begin
      w_new.rs1      = dec_rs1_data;
      w_new.rs2      = dec_rs2_data;
      w_new.pc       = dec_pc;
      w_new.imm      = dec_imm;
      w_new.rs1_addr = dec_rs1_addr;
      w_new.rs2_addr = dec_rs2_addr;
      w_new.sel_a    = dec_sel_a;
      w_new.sel_b    = dec_sel_b;
      w_new.op       = dec_alu_op;
      w_new.rd       = dec_rd;
`ifdef ALU_OPERAND_FWD_EN
      if (w_wb_hit && (wb_rd == dec_rs1_addr)) w_new.rs1 = wb_data;
      if (w_wb_hit && (wb_rd == dec_rs2_addr)) w_new.rs2 = wb_data;
`endif
   end

   // Refresh held operands with a matching write-back (identity when forwarding is off).
   always_comb begin
      w_main_upd = r_main;
      w_skid_upd = r_skid;
`ifdef ALU_OPERAND_FWD_EN
      if (w_wb_hit && (wb_rd == r_main.rs1_addr)) w_main_upd.rs1 = wb_data;
      if (w_wb_hit && (wb_rd == r_main.rs2_addr)) w_main_upd.rs2 = wb_data;
      if (w_wb_hit && (wb_rd == r_skid.rs1_addr)) w_skid_upd.rs1 = wb_data;
      if (w_wb_hit && (wb_rd == r_skid.rs2_addr)) w_skid_upd.rs2 = wb_data;
`endif
   end

   // Occupancy FSM with registered handshake outputs; flush beats everything but reset.
   // Payload is never written when an entry goes invalid, so outputs hold their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_dec_ready <= 1'b1;
         r_ex_valid  <= 1'b0;
      end else if (flush) begin
         r_state     <= S_EMPTY;
         r_dec_ready <= 1'b1;
         r_ex_valid  <= 1'b0;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_main     <= w_new;
                  r_state    <= S_BUSY;
                  r_ex_valid <= 1'b1;
               end
            end
            S_BUSY: begin
               if (w_accept && w_consume) begin
                  r_main <= w_new;
               end else if (w_accept) begin
                  r_main      <= w_main_upd;
                  r_skid      <= w_new;
                  r_state     <= S_FULL;
                  r_dec_ready <= 1'b0;
               end else if (w_consume) begin
                  r_state    <= S_EMPTY;
                  r_ex_valid <= 1'b0;
               end else begin
                  r_main <= w_main_upd;
               end
            end
            S_FULL: begin
               if (w_consume) begin
                  r_main      <= w_skid_upd;
                  r_state     <= S_BUSY;
                  r_dec_ready <= 1'b1;
               end else begin
                  r_main <= w_main_upd;
                  r_skid <= w_skid_upd;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_dec_ready <= 1'b1;
               r_ex_valid  <= 1'b0;
            end
         endcase
      end
   end

   assign dec_ready     = r_dec_ready;
   assign ex_valid      = r_ex_valid;
   assign alu_in_0      = r_main.sel_a ? r_main.pc  : r_main.rs1;
   assign alu_in_1      = r_main.sel_b ? r_main.imm : r_main.rs2;
   assign alu_operation = r_main.op;
   assign ex_rd         = r_main.rd;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_operand_stage                                         |
// | Description : Self-checking bench for alu_operand_stage. Expected ALU      |
// |               operands are queued on every accepted transfer and popped    |
// |               on every consumed transfer. Define ALU_OPERAND_FWD_EN to     |
// |               also exercise write-back forwarding.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_operand_stage;

   localparam logic [3:0] c_ALU_ADD = 4'd0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_rs1_data, dec_rs2_data, dec_pc, dec_imm;
   logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd;
   logic        dec_sel_a, dec_sel_b;
   logic [3:0]  dec_alu_op;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] alu_in_0, alu_in_1;
   logic [3:0]  alu_operation;
   logic [4:0]  ex_rd;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t cur;

   alu_operand_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
      .dec_pc(dec_pc), .dec_imm(dec_imm),
      .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd(dec_rd),
      .dec_sel_a(dec_sel_a), .dec_sel_b(dec_sel_b), .dec_alu_op(dec_alu_op),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
      .alu_operation(alu_operation), .ex_rd(ex_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Drive one decoder beat and remember what the ALU should see for it.
   task automatic drive(input bit v, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm, input bit sa,
                        input bit sbsel, input logic [3:0] op, input logic [4:0] rd);
      dec_valid    = v;
      dec_rs1_data = rs1;
      dec_rs2_data = rs2;
      dec_pc       = pc;
      dec_imm      = imm;
      dec_sel_a    = sa;
      dec_sel_b    = sbsel;
      dec_alu_op   = op;
      dec_rd       = rd;
      dec_rs1_addr = 5'd0;
      dec_rs2_addr = 5'd0;
      cur.a  = sa ? pc : rs1;
      cur.b  = sbsel ? imm : rs2;
      cur.op = op;
      cur.rd = rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = '0;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
      #12;
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL rst_ex_valid: got %b want 0", ex_valid); end
      n_cmp++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL rst_dec_ready: got %b want 1", dec_ready); end
      n_cmp++; if (alu_in_0 !== 32'h0) begin n_err++; $display("FAIL rst_alu_in_0: got %h want 0", alu_in_0); end
      n_cmp++; if (alu_in_1 !== 32'h0) begin n_err++; $display("FAIL rst_alu_in_1: got %h want 0", alu_in_1); end
      n_cmp++; if ({alu_operation, ex_rd} !== 9'h0) begin n_err++; $display("FAIL rst_op_rd: got %h/%0d want 0/0", alu_operation, ex_rd); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_pass();
      exp_t e;
      ex_ready = 1'b1;
      drive(1'b1, 32'd5, 32'd7, 32'h40, 32'h8, 1'b0, 1'b0, c_ALU_ADD, 5'd3);
      #1;
      if (dec_valid && dec_ready) sb.push_back(cur);
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
      #1;
      n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL single_latency: ex_valid got %b want 1", ex_valid); end
      n_cmp++; if ({alu_in_0, alu_in_1, ex_rd} !== {32'd5, 32'd7, 5'd3})
         begin n_err++; $display("FAIL single_out: got %0d/%0d/%0d want 5/7/3", alu_in_0, alu_in_1, ex_rd); end
      if (ex_valid && ex_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin n_err++; $display("FAIL single_sb: output with empty scoreboard"); end
         else begin
            e = sb.pop_front();
            if ({alu_in_0, alu_in_1, alu_operation, ex_rd} !== {e.a, e.b, e.op, e.rd}) begin
               n_err++; $display("FAIL single_sb: got %h/%h/%h/%0d want %h/%h/%h/%0d",
                                 alu_in_0, alu_in_1, alu_operation, ex_rd, e.a, e.b, e.op, e.rd);
            end
         end
      end
      @(posedge clk); #1;
      #1;
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: ex_valid got %b want 0", ex_valid); end
   endtask

   task automatic test_operand_mux();
      exp_t e;
      ex_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         if (c == 0) drive(1'b1, 32'h11, 32'h22, 32'h100, 32'hFFFF_FFFC, 1'b1, 1'b1, 4'd5, 5'd9);
         else        drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
         #1;
         if (ex_valid && ex_ready) begin
            n_cmp++;
            if ({alu_in_0, alu_in_1} !== {32'h100, 32'hFFFF_FFFC})
               begin n_err++; $display("FAIL mux_direct: got %h/%h want 00000100/fffffffc", alu_in_0, alu_in_1); end
            n_cmp++;
            if (sb.size() == 0) begin n_err++; $display("FAIL mux_sb: output with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if ({alu_in_0, alu_in_1, alu_operation, ex_rd} !== {e.a, e.b, e.op, e.rd}) begin
                  n_err++; $display("FAIL mux_sb: got %h/%h/%h/%0d want %h/%h/%h/%0d",
                                    alu_in_0, alu_in_1, alu_operation, ex_rd, e.a, e.b, e.op, e.rd);
               end
            end
         end
         if (dec_valid && dec_ready && !flush) sb.push_back(cur);
         @(posedge clk); #1;
      end
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL mux_left: %0d entries never presented, want 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   pops = 0;
      ex_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (c < 8) drive(1'b1, $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
         else       drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
         #1;
         n_cmp++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want 1", c, dec_ready); end
         n_cmp++; if (ex_valid !== (c != 0)) begin n_err++; $display("FAIL b2b_valid c%0d: got %b want %b", c, ex_valid, c != 0); end
         if (ex_valid && ex_ready) begin
            n_cmp++; pops++;
            if (sb.size() == 0) begin n_err++; $display("FAIL b2b_sb: output with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if ({alu_in_0, alu_in_1, alu_operation, ex_rd} !== {e.a, e.b, e.op, e.rd}) begin
                  n_err++; $display("FAIL b2b_sb c%0d: got %h/%h/%h/%0d want %h/%h/%h/%0d", c,
                                    alu_in_0, alu_in_1, alu_operation, ex_rd, e.a, e.b, e.op, e.rd);
               end
            end
         end
         if (dec_valid && dec_ready && !flush) sb.push_back(cur);
         @(posedge clk); #1;
      end
      n_cmp++; if (pops != 8) begin n_err++; $display("FAIL b2b_count: got %0d outputs want 8", pops); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   pops = 0;
      for (int c = 0; c < 6; c++) begin
         case (c)
            0: begin ex_ready = 1'b0; drive(1'b1, 32'hA0, 32'hA1, 32'h0, 32'h0, 1'b0, 1'b0, 4'd1, 5'd10); end
            1: begin ex_ready = 1'b0; drive(1'b1, 32'hB0, 32'hB1, 32'h0, 32'h0, 1'b0, 1'b0, 4'd2, 5'd11); end
            2: begin ex_ready = 1'b0; drive(1'b1, 32'hC0, 32'hC1, 32'h0, 32'h0, 1'b0, 1'b0, 4'd3, 5'd12); end
            default: begin ex_ready = 1'b1; drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0); end
         endcase
         #1;
         if (c == 2) begin
            n_cmp++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", dec_ready); end
         end
         if (c == 5) begin
            n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: ex_valid got %b want 0", ex_valid); end
         end
         if (ex_valid && ex_ready) begin
            n_cmp++; pops++;
            if (sb.size() == 0) begin n_err++; $display("FAIL bp_sb: output with empty scoreboard"); end
            else begin
               e = sb.pop_front();
               if ({alu_in_0, alu_in_1, alu_operation, ex_rd} !== {e.a, e.b, e.op, e.rd}) begin
                  n_err++; $display("FAIL bp_sb c%0d: got %h/%h/%h/%0d want %h/%h/%h/%0d", c,
                                    alu_in_0, alu_in_1, alu_operation, ex_rd, e.a, e.b, e.op, e.rd);
               end
            end
         end
         if (dec_valid && dec_ready && !flush) sb.push_back(cur);
         @(posedge clk); #1;
      end
      n_cmp++; if (pops != 2) begin n_err++; $display("FAIL bp_count: got %0d outputs want 2", pops); end
   endtask

   task automatic test_flush();
      // FULL with A then B, flush while C is offered.
      ex_ready = 1'b0;
      drive(1'b1, 32'hAA00, 32'hAA01, 32'h0, 32'h0, 1'b0, 1'b0, 4'd4, 5'd1);
      @(posedge clk); #1;
      drive(1'b1, 32'hBB00, 32'hBB01, 32'h0, 32'h0, 1'b0, 1'b0, 4'd4, 5'd2);
      @(posedge clk); #1;
      drive(1'b1, 32'hCC00, 32'hCC01, 32'h0, 32'h0, 1'b0, 1'b0, 4'd4, 5'd3);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; ex_ready = 1'b1;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
      #1;
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_valid: got %b want 0", ex_valid); end
      n_cmp++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL flush_full_ready: got %b want 1", dec_ready); end
      n_cmp++; if (alu_in_0 !== 32'hAA00) begin n_err++; $display("FAIL flush_hold: alu_in_0 got %h want 0000aa00", alu_in_0); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #2;
         n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost c%0d: ex_valid got %b want 0", c, ex_valid); end
      end
      // BUSY with D, flush while E would be accepted.
      @(posedge clk); #1;
      ex_ready = 1'b0;
      drive(1'b1, 32'hD000, 32'hD001, 32'h0, 32'h0, 1'b0, 1'b0, 4'd6, 5'd4);
      @(posedge clk); #1;
      drive(1'b1, 32'hE000, 32'hE001, 32'h0, 32'h0, 1'b0, 1'b0, 4'd7, 5'd5);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; ex_ready = 1'b1;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
      #1;
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_busy_valid: got %b want 0", ex_valid); end
      n_cmp++; if ({alu_in_0, alu_in_1} !== {32'hD000, 32'hD001})
         begin n_err++; $display("FAIL flush_busy_hold: got %h/%h want 0000d000/0000d001", alu_in_0, alu_in_1); end
      @(posedge clk); #2;
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_busy_ghost: ex_valid got %b want 0", ex_valid); end
      sb.delete();
      @(posedge clk); #1;
   endtask

`ifdef ALU_OPERAND_FWD_EN
   task automatic test_forwarding();
      ex_ready = 1'b0;
      drive(1'b1, 32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 5'd7);
      dec_rs1_addr = 5'd4; dec_rs2_addr = 5'd9;
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
      wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h55;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      #1;
      n_cmp++; if ({alu_in_0, alu_in_1} !== {32'h55, 32'h2})
         begin n_err++; $display("FAIL fwd_held: got %h/%h want 00000055/00000002", alu_in_0, alu_in_1); end
      // x0 write-back never forwards, neither on capture nor into a held entry.
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      drive(1'b1, 32'h12, 32'h34, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 5'd8);
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h99;
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
      @(posedge clk); #1;
      wb_valid = 1'b0;
      #1;
      n_cmp++; if ({alu_in_0, alu_in_1} !== {32'h12, 32'h34})
         begin n_err++; $display("FAIL fwd_x0: got %h/%h want 00000012/00000034", alu_in_0, alu_in_1); end
      // Forward on capture into rs2.
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      drive(1'b1, 32'h5, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 5'd8);
      dec_rs2_addr = 5'd6;
      wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'hAB;
      @(posedge clk); #1;
      wb_valid = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
      #1;
      n_cmp++; if ({alu_in_0, alu_in_1} !== {32'h5, 32'hAB})
         begin n_err++; $display("FAIL fwd_capture: got %h/%h want 00000005/000000ab", alu_in_0, alu_in_1); end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask
`endif

   task automatic test_async_reset();
      ex_ready = 1'b0;
      drive(1'b1, 32'h7000, 32'h7001, 32'h0, 32'h0, 1'b0, 1'b0, 4'd9, 5'd20);
      @(posedge clk); #1;
      drive(1'b1, 32'h8000, 32'h8001, 32'h0, 32'h0, 1'b0, 1'b0, 4'd9, 5'd21);
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 5'd0);
      #1;
      n_cmp++; if ({ex_valid, dec_ready} !== 2'b10)
         begin n_err++; $display("FAIL arst_pre_full: ex_valid/dec_ready got %b%b want 10", ex_valid, dec_ready); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", ex_valid); end
      n_cmp++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", dec_ready); end
      n_cmp++; if ({alu_in_0, alu_in_1, alu_operation, ex_rd} !== 73'h0)
         begin n_err++; $display("FAIL arst_payload: got %h/%h/%h/%0d want all 0", alu_in_0, alu_in_1, alu_operation, ex_rd); end
      #2;
      rst_n = 1'b1;
      sb.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_operand_mux();
      test_back_to_back();
      test_backpressure();
      test_flush();
`ifdef ALU_OPERAND_FWD_EN
      test_forwarding();
`endif
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
